// File: rtl/pipe_rca_pkg.sv
// Shared types and elaboration helpers for the pipelined ripple-carry adder
// (pipe_rca_add, rca_seg).
package pipe_rca_pkg;

  // Per-stage record: beat-valid flag and the carry handed to the next stage.
  typedef struct packed {
    logic vld;
    logic c;
  } stage_t;

  function automatic int nseg(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 1;
  endfunction

  function automatic bit seg_legal(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG_W-bit ripple-carry segment; also exposes the carry into
// its MSB so the top stage can derive signed overflow.
module rca_seg
  import pipe_rca_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [SEG_W:0] c_s;

  // Bit-by-bit ripple through the segment.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = ci;
    for (int i = 0; i < SEG_W; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end
  end

  assign co       = c_s[SEG_W];
  assign c_msb_in = c_s[SEG_W-1];

endmodule

// File: rtl/pipe_rca_add.sv
// Pipelined ripple-carry adder, one SEG_W-bit segment per stage, valid/ready
// handshake with a global stall. Define PIPE_RCA_SUB_EN to add the sub port.
module pipe_rca_add
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!seg_legal(WIDTH, SEG_W)) begin : g_bad_params
    $error("pipe_rca_add: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             en_s;
  logic [WIDTH-1:0] bx_s;
  logic             ovf_r;

  // acc_r[k]: sum segments 0..k completed, operand A segments above still pending.
  // bsk_r[k]: remaining B' segments, shifted so the next one sits at bit 0.
  stage_t           st_r      [NSEG];
  logic [WIDTH-1:0] acc_r     [NSEG];
  logic [WIDTH-1:0] bsk_r     [NSEG];
  logic [WIDTH-1:0] base_s    [NSEG];
  logic [WIDTH-1:0] bin_s     [NSEG];
  logic [WIDTH-1:0] acc_nxt_s [NSEG];
  logic [SEG_W-1:0] xs_s      [NSEG];
  logic [SEG_W-1:0] ys_s      [NSEG];
  logic [SEG_W-1:0] s_s       [NSEG];
  logic             cm_s      [NSEG];
  logic [NSEG-1:0]  ci_s;
  logic [NSEG-1:0]  co_s;
  logic [NSEG-1:0]  vin_s;

`ifdef PIPE_RCA_SUB_EN
  assign bx_s = sub ? ~b : b;
`else
  assign bx_s = b;
`endif

  assign out_valid = st_r[NSEG-1].vld;
  assign en_s      = !(out_valid && !out_ready);
  assign in_ready  = en_s;
  assign sum       = acc_r[NSEG-1];
  assign cout      = st_r[NSEG-1].c;
  assign ovf       = ovf_r;

  // Gather each stage's operands, carry-in and valid from its predecessor.
  always_comb begin
    ci_s     = '0;
    vin_s    = '0;
    base_s[0] = a;
    bin_s[0]  = bx_s;
    ci_s[0]   = cin;
    vin_s[0]  = in_valid;
    for (int k = 1; k < NSEG; k++) begin
      base_s[k] = acc_r[k-1];
      bin_s[k]  = bsk_r[k-1];
      ci_s[k]   = st_r[k-1].c;
      vin_s[k]  = st_r[k-1].vld;
    end
    for (int k = 0; k < NSEG; k++) begin
      xs_s[k] = base_s[k][k*SEG_W +: SEG_W];
      ys_s[k] = bin_s[k][SEG_W-1:0];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    rca_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .x        (xs_s[k]),
      .y        (ys_s[k]),
      .ci       (ci_s[k]),
      .s        (s_s[k]),
      .co       (co_s[k]),
      .c_msb_in (cm_s[k])
    );
  end

  // Splice each stage's fresh partial sum into its slot of the travelling word.
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      acc_nxt_s[k]                    = base_s[k];
      acc_nxt_s[k][k*SEG_W +: SEG_W] = s_s[k];
    end
  end

  // Stage registers: cleared by reset, frozen as a whole while the output stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        st_r[k]  <= '0;
        acc_r[k] <= '0;
        bsk_r[k] <= '0;
      end
      ovf_r <= 1'b0;
    end else if (en_s) begin
      for (int k = 0; k < NSEG; k++) begin
        st_r[k]  <= '{vld: vin_s[k], c: co_s[k]};
        acc_r[k] <= acc_nxt_s[k];
        bsk_r[k] <= bin_s[k] >> SEG_W;
      end
      ovf_r <= co_s[NSEG-1] ^ cm_s[NSEG-1];
    end
  end

endmodule

// File: tb/tb_pipe_rca_add.sv
// Scoreboard bench for pipe_rca_add at WIDTH=16, SEG_W=4 (latency 4);
// exercises the sub path too when PIPE_RCA_SUB_EN is defined.
module tb_pipe_rca_add;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;
  localparam int LAT   = 4;

  typedef struct {
    logic [17:0] exp;
    int          cyc;
  } sb_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  sb_t         q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          n_acc = 0;
  bit          lat_chk = 1'b0;
  bit          use_ovr = 1'b0;
  logic [17:0] ovr_exp;

  always #5 clk = ~clk;

  pipe_rca_add #(
    .WIDTH (WIDTH),
    .SEG_W (SEG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_RCA_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Reference: {cout, ovf, sum}; overflow from operand/result sign bits.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [15:0] yy;
    logic [16:0] t;
    logic        ov;
    yy = sb ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {16'b0, ci};
    ov = (x[15] == yy[15]) && (t[15] != x[15]);
    return {t[16], ov, t[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score any output transfer, record any input transfer, advance.
  task automatic cycle();
    logic fire;
    logic acc;
    sb_t  e;
    #2;
    fire = out_valid && out_ready;
    acc  = in_valid && in_ready;
    if (fire) begin
      check("sb_has_entry", {31'b0, (q.size() > 0)}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("result", {14'b0, cout, ovf, sum}, {14'b0, e.exp});
        if (lat_chk) check("latency", cyc - e.cyc, LAT);
      end
    end
    if (acc) begin
      e.exp = use_ovr ? ovr_exp : model(a, b, cin, sub);
      e.cyc = cyc;
      q.push_back(e);
      n_acc++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] xa, input logic [15:0] xb, input logic xc,
                      input logic xs, input logic [17:0] exp);
    int n0;
    n0       = n_acc;
    a        = xa;
    b        = xb;
    cin      = xc;
    sub      = xs;
    use_ovr  = 1'b1;
    ovr_exp  = exp;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    use_ovr  = 1'b0;
    check("directed_accepted", n_acc - n0, 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 64 && q.size() > 0; i++) cycle();
    check("drain_empty", q.size(), 0);
  endtask

  task automatic rand_ops();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom_range(0, 1));
`ifdef PIPE_RCA_SUB_EN
    sub = 1'($urandom_range(0, 1));
`else
    sub = 1'b0;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    int n0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Directed adds with latency check
    lat_chk = 1'b1;
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
    drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    drain();
`ifdef PIPE_RCA_SUB_EN
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    drain();
`endif

    // Back-to-back streaming
    n0 = n_acc;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_ops();
      cycle();
    end
    drain();
    check("stream_accepted", n_acc - n0, 1000);

    // Fill the pipe with the output blocked, then hold for three cycles
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      cycle();
    end
    check("bp_queued", q.size(), 4);
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_held", {14'b0, cout, ovf, sum}, {14'b0, q[0].exp});
      cycle();
    end
    drain();

    // Random valid/ready toggling
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    drain();

    // Reset with three beats in flight
    lat_chk  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      cycle();
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    #1;
    check("mid_reset_out_valid", out_valid, 0);
    check("mid_reset_sum", sum, 0);
    check("mid_reset_cout", cout, 0);
    check("mid_reset_ovf", ovf, 0);
    check("mid_reset_in_ready", in_ready, 1);
    send(16'h1234, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1235});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
